// File: rtl/csel_sub_seq_64.sv
// ---------------------------------------------------------------------------
// csel_sub_seq_64
//
// Multi-cycle subtractor: diff = a - b - bin (modulo 2^WIDTH).
// The subtraction runs as a + ~b + ~bin, one SLICE-wide carry-select slice
// per clock. The carry between slices is kept in a register, so the borrow
// out is simply the inverted final carry.
//
// Operands are latched on accept and shifted right one slice per CALC cycle.
// Each slice result is shifted into the top of the work register, so after
// NSLICE cycles the work register holds the full difference in order.
//
// DONE takes one extra edge to load diff/bout from the work register. That
// is why out_valid rises NSLICE+1 edges after the accept edge.
//
// Optional feature macro: CSEL_SUB_OVF_EN
//   When defined, the ovf output is added. It is the signed two's-complement
//   overflow of the subtraction, registered together with diff.
//
// Parameters:
//   WIDTH      operand width, must be an integer multiple of SLICE
//   SLICE      bits computed per clock
//   NSLICE     derived slice count WIDTH/SLICE (not overridable)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_valid   operands valid
//   in_ready   block can accept operands (registered, 0 during reset)
//   a, b, bin  minuend, subtrahend, borrow in
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts result
//   diff       registered difference
//   bout       registered borrow out (1 when a < b + bin, unsigned)
//   ovf        (CSEL_SUB_OVF_EN only) registered signed overflow
// ---------------------------------------------------------------------------
module csel_sub_seq_64 #(
   parameter int WIDTH = 64,
   parameter int SLICE = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef CSEL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_r;
   logic [WIDTH-1:0]   a_r;
   logic [WIDTH-1:0]   b_r;
   logic [WIDTH-1:0]   work_r;
   logic               carry_r;
   logic [IDX_W-1:0]   idx_r;
   logic               in_ready_r;
   logic               out_valid_r;
   logic [WIDTH-1:0]   diff_r;
   logic               bout_r;
`ifdef CSEL_SUB_OVF_EN
   logic               a_msb_r;
   logic               b_msb_r;
   logic               ovf_r;
`endif

   logic [SLICE:0]       sum0_s;
   logic [SLICE:0]       sum1_s;
   logic [SLICE:0]       sel_s;
   logic [WIDTH+SLICE-1:0] cat_s;
   logic [WIDTH-1:0]     work_nxt_s;

   // Carry-select slice: both carry-in variants precomputed, carry_r picks one.
   always_comb begin
      sum0_s = {1'b0, a_r[SLICE-1:0]} + {1'b0, ~b_r[SLICE-1:0]};
      sum1_s = sum0_s + {{SLICE{1'b0}}, 1'b1};
      if (carry_r) begin
         sel_s = sum1_s;
      end else begin
         sel_s = sum0_s;
      end
   end

   // Shift the new slice into the top of the work register.
   // Building this from a concatenation also keeps it legal when NSLICE == 1.
   always_comb begin
      cat_s      = {sel_s[SLICE-1:0], work_r};
      work_nxt_s = cat_s[WIDTH+SLICE-1:SLICE];
   end

   // Control FSM plus datapath registers and registered handshake outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= IDLE;
         a_r         <= {WIDTH{1'b0}};
         b_r         <= {WIDTH{1'b0}};
         work_r      <= {WIDTH{1'b0}};
         carry_r     <= 1'b0;
         idx_r       <= {IDX_W{1'b0}};
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         diff_r      <= {WIDTH{1'b0}};
         bout_r      <= 1'b0;
`ifdef CSEL_SUB_OVF_EN
         a_msb_r     <= 1'b0;
         b_msb_r     <= 1'b0;
         ovf_r       <= 1'b0;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid && in_ready_r) begin
                  a_r        <= a;
                  b_r        <= b;
                  carry_r    <= ~bin;
                  idx_r      <= {IDX_W{1'b0}};
                  in_ready_r <= 1'b0;
                  state_r    <= CALC;
`ifdef CSEL_SUB_OVF_EN
                  // Operand sign bits are shifted away during CALC, so keep them.
                  a_msb_r    <= a[WIDTH-1];
                  b_msb_r    <= b[WIDTH-1];
`endif
               end else begin
                  // Also raises in_ready on the first edge after reset release.
                  in_ready_r <= 1'b1;
               end
            end

            CALC: begin
               a_r     <= a_r >> SLICE;
               b_r     <= b_r >> SLICE;
               work_r  <= work_nxt_s;
               carry_r <= sel_s[SLICE];
               if (idx_r == LAST_IDX) begin
                  idx_r   <= {IDX_W{1'b0}};
                  state_r <= DONE;
               end else begin
                  idx_r   <= idx_r + IDX_ONE;
               end
            end

            DONE: begin
               if (!out_valid_r) begin
                  // Entry edge: publish the finished result.
                  diff_r      <= work_r;
                  bout_r      <= ~carry_r;
                  out_valid_r <= 1'b1;
`ifdef CSEL_SUB_OVF_EN
                  ovf_r       <= (a_msb_r != b_msb_r) && (work_r[WIDTH-1] != a_msb_r);
`endif
               end else if (out_ready) begin
                  // diff/bout stay as they are; only out_valid drops.
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state_r     <= IDLE;
               end else begin
                  out_valid_r <= 1'b1;
               end
            end

            default: begin
               state_r     <= IDLE;
               in_ready_r  <= 1'b0;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign diff      = diff_r;
   assign bout      = bout_r;
`ifdef CSEL_SUB_OVF_EN
   assign ovf       = ovf_r;
`endif

endmodule

// File: tb/tb_csel_sub_seq_64.sv
// ---------------------------------------------------------------------------
// tb_csel_sub_seq_64
//
// Self-checking bench for csel_sub_seq_64.
// A table of operand/expected-result records is applied in a loop. Expected
// results go into a scoreboard queue when the operands are accepted, and are
// popped when out_valid rises. Hand-written sequences cover backpressure,
// ignored in_valid, and asynchronous reset in the middle of CALC.
// ---------------------------------------------------------------------------
module tb_csel_sub_seq_64;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] a;
   logic [63:0] b;
   logic        bin;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] diff;
   logic        bout;
`ifdef CSEL_SUB_OVF_EN
   logic        ovf;
`endif

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic        bin;
      logic [63:0] d;
      logic        bo;
      logic        ov;
   } vec_t;

   typedef struct {
      logic [63:0] d;
      logic        bo;
      logic        ov;
   } res_t;

   vec_t vecs[10];
   res_t exp_q[$];
   res_t last_exp;
   int   checks;
   int   errors;

   csel_sub_seq_64 dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout)
`ifdef CSEL_SUB_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b required=%b", name, act, exp);
      end
   endtask

   // Wait for in_ready, present operands, pass the accept edge, and push the expectation.
   task automatic accept_op(input vec_t v);
      int n;
      n = 0;
      while (!in_ready && n < 20) begin
         step();
         n++;
      end
      chk1("ready_timeout_ok", in_ready, 1'b1);
      a        = v.a;
      b        = v.b;
      bin      = v.bin;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      a        = 64'hDEAD_BEEF_DEAD_BEEF;
      b        = 64'h0123_4567_89AB_CDEF;
      bin      = 1'b1;
      exp_q.push_back('{d: v.d, bo: v.bo, ov: v.ov});
   endtask

   // From just after the accept edge: count edges to out_valid, then pop and compare.
   task automatic wait_result(input string tag);
      int  lat;
      logic busy_ok;
      res_t e;
      lat     = 0;
      busy_ok = 1'b1;
      while (!out_valid && lat < 20) begin
         if (in_ready) busy_ok = 1'b0;
         step();
         lat++;
      end
      chk64({tag, "_latency"}, 64'(lat), 64'd5);
      chk1({tag, "_in_ready_low"}, busy_ok & ~in_ready, 1'b1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
      end else begin
         e = '{d: 64'hX, bo: 1'bX, ov: 1'bX};
      end
      last_exp = e;
      chk64({tag, "_diff"}, diff, e.d);
      chk1({tag, "_bout"}, bout, e.bo);
`ifdef CSEL_SUB_OVF_EN
      chk1({tag, "_ovf"}, ovf, e.ov);
`endif
   endtask

   // One-cycle output handshake; result must hold while out_valid drops.
   task automatic handshake(input string tag);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk1({tag, "_out_valid_drop"}, out_valid, 1'b0);
      chk64({tag, "_diff_hold"}, diff, last_exp.d);
      chk1({tag, "_in_ready_back"}, in_ready, 1'b1);
   endtask

   initial begin
      logic stable_ok;
      logic no_ov_ok;
      vec_t v;

      checks = 0;
      errors = 0;

      vecs[0] = '{64'd100, 64'd1, 1'b0, 64'd99, 1'b0, 1'b0};
      vecs[1] = '{64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
      vecs[2] = '{64'h0000_0000_0001_0000, 64'd1, 1'b0, 64'h0000_0000_0000_FFFF, 1'b0, 1'b0};
      vecs[3] = '{64'h0001_0000_0000_0000, 64'd1, 1'b0, 64'h0000_FFFF_FFFF_FFFF, 1'b0, 1'b0};
      vecs[4] = '{64'd5, 64'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
      vecs[5] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1};
      vecs[6] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 1'b1};
      vecs[7] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 64'h0246_8ACF_1357_9BCF, 1'b0, 1'b0};
      vecs[8] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
      vecs[9] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};

      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = 64'd0;
      b         = 64'd0;
      bin       = 1'b0;

      // Reset state
      #2;
      chk1("rst_in_ready", in_ready, 1'b0);
      chk1("rst_out_valid", out_valid, 1'b0);
      chk64("rst_diff", diff, 64'd0);
      chk1("rst_bout", bout, 1'b0);
      step();
      step();
      rst = 1'b1;
      step();
      chk1("post_rst_in_ready", in_ready, 1'b1);

      // Table-driven vectors
      for (int i = 0; i < 10; i++) begin
         accept_op(vecs[i]);
         wait_result($sformatf("vec%0d", i));
         handshake($sformatf("vec%0d", i));
      end

      // Backpressure: hold the result while in_valid is driven with new operands.
      accept_op(vecs[0]);
      wait_result("bp");
      a         = 64'd7;
      b         = 64'd2;
      bin       = 1'b0;
      in_valid  = 1'b1;
      stable_ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         if (!out_valid || diff !== 64'd99 || bout !== 1'b0 || in_ready) stable_ok = 1'b0;
      end
      chk1("bp_stable", stable_ok, 1'b1);
      last_exp = '{d: 64'd99, bo: 1'b0, ov: 1'b0};
      handshake("bp");
      step();
      chk1("bp_new_accepted", in_ready, 1'b0);
      in_valid = 1'b0;
      exp_q.push_back('{d: 64'd5, bo: 1'b0, ov: 1'b0});
      wait_result("bp_next");
      handshake("bp_next");

      // Asynchronous reset two cycles into CALC.
      v = '{64'hABCD_0000_1234_5678, 64'h0000_FFFF_0000_0001, 1'b0, 64'd0, 1'b0, 1'b0};
      accept_op(v);
      void'(exp_q.pop_back());
      step();
      step();
      #2;
      rst = 1'b0;
      #1;
      chk1("arst_out_valid", out_valid, 1'b0);
      chk64("arst_diff", diff, 64'd0);
      chk1("arst_bout", bout, 1'b0);
      chk1("arst_in_ready", in_ready, 1'b0);
      step();
      step();
      rst = 1'b1;
      step();
      chk1("arst_release_in_ready", in_ready, 1'b1);
      no_ov_ok = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         if (out_valid) no_ov_ok = 1'b0;
      end
      chk1("arst_no_stale_valid", no_ov_ok, 1'b1);
      accept_op(vecs[5]);
      wait_result("arst_after");
      handshake("arst_after");

      chk64("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
